// File: rtl/ahb_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_if
// Purpose  : AHB-Lite bus bundle between one master, N slaves and the
//            interconnect. Carries the master address phase, the per-slave
//            select lines, the muxed response back to the master and the
//            flattened per-slave response buses.
// Modports : master - traffic source side (master plus slave models): drives
//                     address/control and the per-slave responses.
//            slave  - interconnect side: decodes address/control, returns
//                     hsel and the muxed response.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_lite_if #(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
);
  logic [ADDR_W-1:0]            haddr;
  logic [1:0]                   htrans;
  logic                         hwrite;
  logic [2:0]                   hsize;
  logic [NUM_SLAVES-1:0]        hsel;
  logic                         hready;
  logic                         hresp;
  logic [DATA_W-1:0]            hrdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_hrdata;
  logic [NUM_SLAVES-1:0]        s_hreadyout;
  logic [NUM_SLAVES-1:0]        s_hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, s_hrdata, s_hreadyout, s_hresp,
    input  hsel, hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, s_hrdata, s_hreadyout, s_hresp,
    output hsel, hready, hresp, hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_interconnect
// Purpose  : Single-master AHB-Lite interconnect for NUM_SLAVES slaves.
//            Address-phase region decode drives hsel; a registered data-phase
//            select steers the chosen slave's response back to the master.
//            Unmapped active transfers are answered by a built-in default
//            slave with the two-cycle ERROR response, counted in err_cnt and
//            their address captured in last_err_addr.
// Ports    : clk           - system clock, rising edge
//            reset         - asynchronous active-low reset
//            bus           - ahb_lite_if.slave bundle (master + slave buses)
//            err_cnt       - saturating count of completed ERROR responses
//            last_err_addr - haddr of the most recent unmapped active transfer
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_interconnect #(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAP_MSB    = 31,
  parameter int MAP_LSB    = 28,
  parameter logic [NUM_SLAVES*(MAP_MSB-MAP_LSB+1)-1:0] BASE_VEC = {4'hB, 4'hA},
  parameter int ERR_CNT_W  = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  ahb_lite_if.slave                 bus,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic [ADDR_W-1:0]         last_err_addr
);

  localparam int c_RGN_W = MAP_MSB - MAP_LSB + 1;
  localparam int c_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ERR_CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    DSEL_IDLE    = 2'd0,
    DSEL_SLAVE   = 2'd1,
    DSEL_DEFAULT = 2'd2
  } dsel_kind_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [c_RGN_W-1:0]    w_region;
  logic                  w_match;
  logic [c_IDX_W-1:0]    w_idx;
  logic [NUM_SLAVES-1:0] w_hsel;
  logic                  w_active;
  logic                  w_unmapped_req;
  logic                  w_hready;
  logic                  w_hresp;
  logic [DATA_W-1:0]     w_hrdata;
  logic                  w_ds_hready;
  logic                  w_ds_hresp;
  ds_state_t             w_ds_next;

  dsel_kind_t            r_dsel_kind;
  logic [c_IDX_W-1:0]    r_dsel_idx;
  ds_state_t             r_ds_state;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0]     r_last_err_addr;

  // hwrite/hsize are pass-through for the slaves; htrans[0] (SEQ vs NONSEQ,
  // IDLE vs BUSY) never changes routing.
  logic w_unused;
  assign w_unused = ^{bus.htrans[0], bus.hwrite, bus.hsize};

  // Address decode. Scanning from the top index down lets the lowest
  // matching index overwrite, keeping hsel one-hot on overlapping regions.
  assign w_region = bus.haddr[MAP_MSB:MAP_LSB];

  always_comb begin
    w_match = 1'b0;
    w_idx   = '0;
    w_hsel  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_region == BASE_VEC[i*c_RGN_W +: c_RGN_W]) begin
        w_match = 1'b1;
        w_idx   = c_IDX_W'(i);
      end
    end
    if (w_match) begin
      w_hsel[w_idx] = 1'b1;
    end
  end

  assign bus.hsel       = w_hsel;
  assign w_active       = bus.htrans[1];
  assign w_unmapped_req = w_active && !w_match;

  // Default-slave outputs are a pure function of its state, which keeps the
  // hready feedback into the next-state logic free of combinational loops.
  assign w_ds_hready = (r_ds_state != DS_ERR1);
  assign w_ds_hresp  = (r_ds_state != DS_IDLE);

  // Data-phase response mux.
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = '0;
    case (r_dsel_kind)
      DSEL_SLAVE: begin
        w_hready = bus.s_hreadyout[r_dsel_idx];
        w_hresp  = bus.s_hresp[r_dsel_idx];
        w_hrdata = bus.s_hrdata[r_dsel_idx*DATA_W +: DATA_W];
      end
      DSEL_DEFAULT: begin
        w_hready = w_ds_hready;
        w_hresp  = w_ds_hresp;
      end
      default: ;
    endcase
  end

  assign bus.hready = w_hready;
  assign bus.hresp  = w_hresp;
  assign bus.hrdata = w_hrdata;

  // Data-phase select: only advances when the current data phase completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dsel_kind <= DSEL_IDLE;
      r_dsel_idx  <= '0;
    end else if (w_hready) begin
      if (!w_active) begin
        r_dsel_kind <= DSEL_IDLE;
      end else if (w_match) begin
        r_dsel_kind <= DSEL_SLAVE;
        r_dsel_idx  <= w_idx;
      end else begin
        r_dsel_kind <= DSEL_DEFAULT;
      end
    end
  end

  // Default-slave FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ds_state <= DS_IDLE;
    end else begin
      r_ds_state <= w_ds_next;
    end
  end

  // Default-slave FSM: next state. hready is high in DS_ERR2, so a new
  // unmapped transfer accepted there chains straight into another ERROR.
  always_comb begin
    w_ds_next = r_ds_state;
    case (r_ds_state)
      DS_IDLE: if (w_hready && w_unmapped_req) w_ds_next = DS_ERR1;
      DS_ERR1: w_ds_next = DS_ERR2;
      DS_ERR2: w_ds_next = w_unmapped_req ? DS_ERR1 : DS_IDLE;
      default: w_ds_next = DS_IDLE;
    endcase
  end

  // Debug: saturating error counter and unmapped-address capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt       <= '0;
      r_last_err_addr <= '0;
    end else begin
      if (r_ds_state == DS_ERR2 && r_err_cnt != c_CNT_MAX) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (r_ds_state != DS_ERR1 && w_ds_next == DS_ERR1) begin
        r_last_err_addr <= bus.haddr;
      end
    end
  end

  assign err_cnt       = r_err_cnt;
  assign last_err_addr = r_last_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_interconnect
// Purpose  : Self-checking bench for ahb_lite_interconnect. Directed
//            scenarios cover reset, zero-wait reads, slave wait states,
//            pipelining, default-slave ERROR handling, counter saturation
//            (second instance with a 2-bit counter) and asynchronous reset
//            during an ERROR. A randomized phase runs against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_interconnect;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  err_cnt;
  logic [31:0] last_err_addr;
  logic [1:0]  err_cnt2;
  logic [31:0] last_err_addr2;
  int          vectors     = 0;
  int          miscompares = 0;

  ahb_lite_if #(.NUM_SLAVES(N), .DATA_W(DW), .ADDR_W(AW)) bus  ();
  ahb_lite_if #(.NUM_SLAVES(N), .DATA_W(DW), .ADDR_W(AW)) bus2 ();

  // The narrow-counter instance sees exactly the same traffic.
  assign bus2.haddr       = bus.haddr;
  assign bus2.htrans      = bus.htrans;
  assign bus2.hwrite      = bus.hwrite;
  assign bus2.hsize       = bus.hsize;
  assign bus2.s_hrdata    = bus.s_hrdata;
  assign bus2.s_hreadyout = bus.s_hreadyout;
  assign bus2.s_hresp     = bus.s_hresp;

  always #5 clk = ~clk;

  ahb_lite_interconnect #(.NUM_SLAVES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .err_cnt       (err_cnt),
    .last_err_addr (last_err_addr)
  );

  ahb_lite_interconnect #(.NUM_SLAVES(N), .DATA_W(DW), .ADDR_W(AW), .ERR_CNT_W(2)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus2.slave),
    .err_cnt       (err_cnt2),
    .last_err_addr (last_err_addr2)
  );

  // Memory map as a table: slave i owns the 256 MB region base_tab[i].
  function automatic int target(input logic [31:0] a);
    int base_tab [N] = '{4'hA, 4'hB};
    for (int i = 0; i < N; i++) begin
      if (int'(a[31:28]) == base_tab[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    bus.htrans = T_IDLE;
    bus.haddr  = '0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.haddr = 32'hA000_0004;
    step();
    step();
    sample();
    vectors++; if (bus.hsel !== 2'b01) begin miscompares++; $display("FAIL reset_hsel: got %b expected 01", bus.hsel); end
    vectors++; if (bus.hready !== 1'b1) begin miscompares++; $display("FAIL reset_hready: got %b expected 1", bus.hready); end
    vectors++; if (bus.hresp !== 1'b0) begin miscompares++; $display("FAIL reset_hresp: got %b expected 0", bus.hresp); end
    vectors++; if (bus.hrdata !== 32'h0) begin miscompares++; $display("FAIL reset_hrdata: got %h expected 0", bus.hrdata); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    vectors++; if (last_err_addr !== 32'h0) begin miscompares++; $display("FAIL reset_last_err: got %h expected 0", last_err_addr); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_mapped_read();
    step();
    bus.haddr = 32'hA000_0004; bus.htrans = T_NONSEQ; bus.hwrite = 1'b0;
    sample();
    vectors++; if (bus.hsel !== 2'b01) begin miscompares++; $display("FAIL read_hsel: got %b expected 01", bus.hsel); end
    step();
    bus.haddr = '0; bus.htrans = T_IDLE;
    bus.s_hrdata = {32'h0, 32'h0000_0013}; bus.s_hreadyout = 2'b11;
    sample();
    vectors++; if (bus.hrdata !== 32'h13) begin miscompares++; $display("FAIL read_hrdata: got %h expected 00000013", bus.hrdata); end
    vectors++; if (bus.hready !== 1'b1) begin miscompares++; $display("FAIL read_hready: got %b expected 1", bus.hready); end
    vectors++; if (bus.hresp !== 1'b0) begin miscompares++; $display("FAIL read_hresp: got %b expected 0", bus.hresp); end
    step();
    bus.s_hrdata = '0;
  endtask

  task automatic test_wait_states();
    step();
    bus.haddr = 32'hB000_0000; bus.htrans = T_NONSEQ; bus.hwrite = 1'b1;
    sample();
    vectors++; if (bus.hsel !== 2'b10) begin miscompares++; $display("FAIL wait_hsel: got %b expected 10", bus.hsel); end
    step();
    bus.haddr = 32'hA000_0008; bus.htrans = T_NONSEQ; bus.hwrite = 1'b0;
    bus.s_hreadyout = 2'b01; bus.s_hrdata = {32'h0, 32'h0000_0055};
    sample();
    vectors++; if (bus.hready !== 1'b0) begin miscompares++; $display("FAIL wait_stall1: got %b expected 0", bus.hready); end
    vectors++; if (bus.hsel !== 2'b01) begin miscompares++; $display("FAIL wait_next_hsel: got %b expected 01", bus.hsel); end
    step();
    sample();
    vectors++; if (bus.hready !== 1'b0) begin miscompares++; $display("FAIL wait_stall2: got %b expected 0", bus.hready); end
    step();
    bus.s_hreadyout = 2'b11;
    sample();
    vectors++; if (bus.hready !== 1'b1) begin miscompares++; $display("FAIL wait_release: got %b expected 1", bus.hready); end
    step();
    bus.haddr = '0; bus.htrans = T_IDLE; bus.s_hrdata = {32'h0000_0066, 32'h0000_0055};
    sample();
    vectors++; if (bus.hrdata !== 32'h55) begin miscompares++; $display("FAIL wait_next_data: got %h expected 00000055", bus.hrdata); end
    step();
    bus.s_hrdata = '0;
  endtask

  task automatic test_pipelined();
    step();
    bus.haddr = 32'hB000_0004; bus.htrans = T_NONSEQ;
    sample();
    vectors++; if (bus.hsel !== 2'b10) begin miscompares++; $display("FAIL pipe_hsel1: got %b expected 10", bus.hsel); end
    step();
    bus.haddr = 32'hA000_0008; bus.htrans = T_NONSEQ;
    bus.s_hrdata = {32'h8765_4321, 32'hDEAD_BEEF};
    sample();
    vectors++; if (bus.hrdata !== 32'h8765_4321) begin miscompares++; $display("FAIL pipe_data1: got %h expected 87654321", bus.hrdata); end
    vectors++; if (bus.hsel !== 2'b01) begin miscompares++; $display("FAIL pipe_hsel2: got %b expected 01", bus.hsel); end
    step();
    bus.haddr = '0; bus.htrans = T_IDLE;
    bus.s_hrdata = {32'h1111_1111, 32'hDEAD_BEEF};
    sample();
    vectors++; if (bus.hrdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL pipe_data2: got %h expected deadbeef", bus.hrdata); end
    step();
    sample();
    vectors++; if (bus.hrdata !== 32'h0) begin miscompares++; $display("FAIL pipe_idle_data: got %h expected 0", bus.hrdata); end
    bus.s_hrdata = '0;
  endtask

  task automatic test_unmapped();
    step();
    bus.haddr = 32'hC000_0000; bus.htrans = T_NONSEQ;
    sample();
    vectors++; if (bus.hsel !== 2'b00) begin miscompares++; $display("FAIL unmap_hsel: got %b expected 00", bus.hsel); end
    step();
    bus.haddr = '0; bus.htrans = T_IDLE;
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b01) begin miscompares++; $display("FAIL unmap_err1: got %b expected 01", {bus.hready, bus.hresp}); end
    vectors++; if (bus.hrdata !== 32'h0) begin miscompares++; $display("FAIL unmap_hrdata: got %h expected 0", bus.hrdata); end
    step();
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b11) begin miscompares++; $display("FAIL unmap_err2: got %b expected 11", {bus.hready, bus.hresp}); end
    step();
    bus.haddr = 32'hC000_0000; bus.htrans = T_IDLE;
    sample();
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL unmap_err_cnt: got %0d expected 1", err_cnt); end
    vectors++; if (last_err_addr !== 32'hC000_0000) begin miscompares++; $display("FAIL unmap_last: got %h expected c0000000", last_err_addr); end
    step();
    bus.haddr = '0;
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b10) begin miscompares++; $display("FAIL unmap_idle_okay: got %b expected 10", {bus.hready, bus.hresp}); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL unmap_idle_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    step();
    bus.haddr = 32'hC000_0000; bus.htrans = T_NONSEQ;
    step();
    bus.haddr = 32'hD000_0000; bus.htrans = T_NONSEQ;
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b01) begin miscompares++; $display("FAIL b2b_a_err1: got %b expected 01", {bus.hready, bus.hresp}); end
    step();
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b11) begin miscompares++; $display("FAIL b2b_a_err2: got %b expected 11", {bus.hready, bus.hresp}); end
    step();
    bus.haddr = '0; bus.htrans = T_IDLE;
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b01) begin miscompares++; $display("FAIL b2b_b_err1: got %b expected 01", {bus.hready, bus.hresp}); end
    vectors++; if (last_err_addr !== 32'hD000_0000) begin miscompares++; $display("FAIL b2b_last: got %h expected d0000000", last_err_addr); end
    step();
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b11) begin miscompares++; $display("FAIL b2b_b_err2: got %b expected 11", {bus.hready, bus.hresp}); end
    step();
    sample();
    vectors++; if ({bus.hready, bus.hresp} !== 2'b10) begin miscompares++; $display("FAIL b2b_done: got %b expected 10", {bus.hready, bus.hresp}); end
    vectors++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL b2b_err_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_saturate();
    pulse_reset();
    step();
    bus.haddr = 32'hE000_0000; bus.htrans = T_NONSEQ;
    // Held NONSEQ is accepted on five hready-high edges: five ERRORs.
    repeat (9) @(posedge clk);
    #1;
    bus.haddr = '0; bus.htrans = T_IDLE;
    @(posedge clk);
    @(posedge clk);
    sample();
    vectors++; if (err_cnt !== 8'd5) begin miscompares++; $display("FAIL sat_wide_cnt: got %0d expected 5", err_cnt); end
    vectors++; if (err_cnt2 !== 2'd3) begin miscompares++; $display("FAIL sat_narrow_cnt: got %0d expected 3", err_cnt2); end
    vectors++; if (last_err_addr2 !== 32'hE000_0000) begin miscompares++; $display("FAIL sat_last: got %h expected e0000000", last_err_addr2); end
  endtask

  task automatic test_reset_mid_error();
    step();
    bus.haddr = 32'hC000_0000; bus.htrans = T_NONSEQ;
    step();
    bus.haddr = '0; bus.htrans = T_IDLE;
    vectors++; if (bus.hready !== 1'b0) begin miscompares++; $display("FAIL rme_in_err1: got %b expected 0", bus.hready); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if ({bus.hready, bus.hresp} !== 2'b10) begin miscompares++; $display("FAIL rme_async_resp: got %b expected 10", {bus.hready, bus.hresp}); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rme_err_cnt: got %0d expected 0", err_cnt); end
    vectors++; if (last_err_addr !== 32'h0) begin miscompares++; $display("FAIL rme_last: got %h expected 0", last_err_addr); end
    #1;
    reset = 1'b1;
    step();
    bus.haddr = 32'hA000_0004; bus.htrans = T_NONSEQ;
    step();
    bus.haddr = '0; bus.htrans = T_IDLE; bus.s_hrdata = {32'h0, 32'h0000_0013};
    sample();
    vectors++; if (bus.hrdata !== 32'h13) begin miscompares++; $display("FAIL rme_read_data: got %h expected 00000013", bus.hrdata); end
    vectors++; if ({bus.hready, bus.hresp} !== 2'b10) begin miscompares++; $display("FAIL rme_read_resp: got %b expected 10", {bus.hready, bus.hresp}); end
    step();
    bus.s_hrdata = '0;
  endtask

  // Transaction-level model: each accepted transfer becomes the pending data
  // phase (none / slave k with a wait count / default slave ERROR phase).
  task automatic test_random();
    int             pend, pwait, phase, tgt, mx_err;
    logic [31:0]    pdata, caddr, mlast, e_data;
    logic [1:0]     ctrans;
    logic [31:0]    sd [N];
    logic [N-1:0]   srdy, sresp, e_hsel;
    logic           e_rdy, e_resp;
    logic [3:0]     rgn;

    pulse_reset();
    step();
    pend = -1; pwait = 0; phase = 0; mx_err = 0; mlast = '0; pdata = '0;
    rgn = 4'hA; caddr = 32'hA000_0000; ctrans = T_NONSEQ;
    for (int c = 0; c < 400; c++) begin
      bus.haddr = caddr; bus.htrans = ctrans;
      bus.hwrite = 1'($urandom); bus.hsize = 3'd2;
      for (int j = 0; j < N; j++) begin
        if (pend == j) begin
          srdy[j] = (pwait == 0);
          sd[j]   = srdy[j] ? pdata : $urandom;
          sresp[j] = 1'b0;
        end else begin
          srdy[j] = 1'($urandom); sd[j] = $urandom; sresp[j] = 1'($urandom);
        end
        bus.s_hrdata[j*DW +: DW] = sd[j];
      end
      bus.s_hreadyout = srdy; bus.s_hresp = sresp;

      if (pend < 0) begin
        e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
      end else if (pend == N) begin
        e_rdy = (phase == 2); e_resp = 1'b1; e_data = '0;
      end else begin
        e_rdy = srdy[pend]; e_resp = sresp[pend]; e_data = sd[pend];
      end
      tgt = target(caddr);
      e_hsel = (tgt < 0) ? '0 : N'(1 << tgt);

      sample();
      vectors++; if (bus.hsel !== e_hsel) begin miscompares++; $display("FAIL rnd_hsel c=%0d: got %b expected %b", c, bus.hsel, e_hsel); end
      vectors++; if (bus.hready !== e_rdy) begin miscompares++; $display("FAIL rnd_hready c=%0d: got %b expected %b", c, bus.hready, e_rdy); end
      vectors++; if (bus.hresp !== e_resp) begin miscompares++; $display("FAIL rnd_hresp c=%0d: got %b expected %b", c, bus.hresp, e_resp); end
      vectors++; if (bus.hrdata !== e_data) begin miscompares++; $display("FAIL rnd_hrdata c=%0d: got %h expected %h", c, bus.hrdata, e_data); end
      vectors++; if (err_cnt !== 8'(mx_err)) begin miscompares++; $display("FAIL rnd_err_cnt c=%0d: got %0d expected %0d", c, err_cnt, mx_err); end
      vectors++; if (last_err_addr !== mlast) begin miscompares++; $display("FAIL rnd_last c=%0d: got %h expected %h", c, last_err_addr, mlast); end

      @(posedge clk);
      if (pend == N && phase == 2) mx_err = (mx_err == 255) ? 255 : mx_err + 1;
      if (e_rdy) begin
        if (ctrans[1]) begin
          if (tgt < 0) begin
            pend = N; phase = 1; mlast = caddr;
          end else begin
            pend = tgt; pwait = $urandom_range(0, 2); pdata = $urandom;
          end
        end else begin
          pend = -1;
        end
        case ($urandom_range(0, 4))
          0, 1:    rgn = 4'hA;
          2:       rgn = 4'hB;
          3:       rgn = 4'hC;
          default: rgn = 4'($urandom);
        endcase
        caddr  = {rgn, 28'($urandom)};
        ctrans = 2'($urandom);
      end else if (pend == N) begin
        phase = 2;
      end else begin
        pwait--;
      end
      #1;
    end
    bus.htrans = T_IDLE; bus.s_hreadyout = '1;
  endtask

  initial begin
    bus.haddr = '0; bus.htrans = T_IDLE; bus.hwrite = 1'b0; bus.hsize = 3'd2;
    bus.s_hrdata = '0; bus.s_hreadyout = '1; bus.s_hresp = '0;
    test_reset();
    test_mapped_read();
    test_wait_states();
    test_pipelined();
    test_unmapped();
    test_back_to_back();
    test_saturate();
    test_reset_mid_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
Parametrised AHB-Lite single-master interconnect for N slaves. It replaces the fixed two-slave decoder/mux pair with one block. Address-phase decode drives the per-slave hsel lines. A registered data-phase select steers each slave's hrdata, hreadyout and hresp back to the master. A built-in default slave returns the two-cycle AHB ERROR response for unmapped addresses, and an error counter plus address capture support debug.

Parameters:
NUM_SLAVES, 2, number of attached slaves (1..16)
DATA_W, 32, data bus width
ADDR_W, 32, address bus width
MAP_MSB, 31, top bit of region-select field in haddr
MAP_LSB, 28, bottom bit of region-select field in haddr
BASE_VEC, {4'hB,4'hA}, flattened region values; slice i = region of slave i (default: slave0 ROM 0xA, slave1 RAM 0xB)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
haddr  in  ADDR_W  master address
htrans  in  2  master transfer type
hwrite  in  1  master write strobe (pass-through, not decoded)
hsize  in  3  master transfer size (pass-through, not decoded)
hsel  out  NUM_SLAVES  one-hot address-phase slave select
hready  out  1  muxed ready to master and all slaves
hresp  out  1  muxed response to master
hrdata  out  DATA_W  muxed read data to master
s_hrdata  in  NUM_SLAVES*DATA_W  slave read data, slice i = slave i
s_hreadyout  in  NUM_SLAVES  slave ready outputs
s_hresp  in  NUM_SLAVES  slave responses
err_cnt  out  ERR_CNT_W  count of completed default-slave ERROR responses
last_err_addr  out  ADDR_W  haddr of most recent unmapped active transfer

Behaviour:
- Decode (combinational): match[i] = (haddr[MAP_MSB:MAP_LSB] == BASE_VEC slice i).
  - Multiple matches: the lowest index wins, so hsel stays one-hot.
  - No match: hsel = 0 and the default slave is the target.
  - hsel is not gated by htrans; slaves qualify with htrans themselves.
- Data-phase select register dsel, one of {IDLE, SLAVE[i], DEFAULT}:
  - Updates only on a rising clk where hready = 1.
  - htrans[1] = 1 (NONSEQ/SEQ): load the decoded target.
  - htrans = IDLE/BUSY: load IDLE.
  - hready = 0: dsel holds, covering slave wait states of any length.
- Output mux:
  - dsel = SLAVE[i]: hready/hresp/hrdata = s_hreadyout[i]/s_hresp[i]/s_hrdata slice i.
  - dsel = IDLE: hready = 1, hresp = 0, hrdata = 0.
  - dsel = DEFAULT: driven by the default-slave FSM, hrdata = 0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 when hready = 1, htrans[1] = 1 and there is no match.
  - DS_ERR1 drives hready = 0, hresp = 1, then always -> DS_ERR2.
  - DS_ERR2 drives hready = 1, hresp = 1.
    - Next state: DS_ERR1 if another unmapped active transfer is presented this cycle, else DS_IDLE.
  - An unmapped IDLE/BUSY transfer gets a zero-wait OKAY and no count.
- err_cnt:
  - Increments by 1 on each cycle in DS_ERR2.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
- last_err_addr: loads haddr on the same edge as the DS_IDLE/DS_ERR2 -> DS_ERR1 transition.
- Latency: select is decoded in the address phase, response is muxed in the following data phase. Zero added wait states for mapped slaves.
- Reset (reset = 0, asynchronous):
  - dsel = IDLE, FSM = DS_IDLE.
  - hready = 1, hresp = 0, hrdata = 0, err_cnt = 0, last_err_addr = 0.
  - hsel remains a combinational function of haddr.
- Reset asserted mid-transfer: an in-flight wait state or ERROR is abandoned immediately and outputs reach reset values without a clock edge.

Test Plan:
- Reset, then NONSEQ read haddr=0xA000_0004 with slave0 returning 0x0000_0013, zero-wait -> hsel=2'b01 in address phase; next cycle hrdata=0x0000_0013, hready=1, hresp=0.
- NONSEQ write 0xB000_0000; slave1 holds hreadyout=0 for 2 cycles -> hsel=2'b10; master hready=0 for 2 cycles then 1; dsel held; next address phase is accepted only after the stall.
- Pipelined read 0xB000_0004 followed by read 0xA000_0008; slaves return 0x87654321 and 0xDEADBEEF -> hrdata shows 0x87654321 then 0xDEADBEEF on consecutive cycles with no mixing.
- NONSEQ to 0xC000_0000 -> hsel=0; data phase gives cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1; err_cnt=1; last_err_addr=0xC000_0000. IDLE to 0xC000_0000 -> OKAY, err_cnt stays 1.
- Back-to-back NONSEQ to 0xC000_0000 and 0xD000_0000 -> two complete ERROR pairs with no gap; err_cnt=2; last_err_addr=0xD000_0000. With ERR_CNT_W=2, a 5th error leaves err_cnt=3.
- reset driven low during DS_ERR1 -> hready=1, hresp=0, err_cnt=0 before the next clk edge; after release, a ROM read at 0xA000_0004 completes normally.
